// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that packs FRAME_BYTES good bytes into one frame word.
// Adds false-start rejection, stop-bit checking and idle-gap resync of partial frames.
module uart_frame_rx #(
  parameter int unsigned CLKS_PER_BIT      = 434,
  parameter int unsigned FRAME_BYTES       = 5,
  parameter int unsigned IDLE_TIMEOUT_BITS = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     serial,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  output logic                     frame_err,
  output logic                     timeout,
  output logic [2:0]               state
);

  localparam int unsigned TIMEOUT_CYCLES = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > CLKS_PER_BIT) ? TIMEOUT_CYCLES : CLKS_PER_BIT;
  localparam int unsigned CW  = $clog2(CNT_MAX + 1);
  localparam int unsigned BCW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [1:0]               r_sync;
  logic                     w_rx;
  logic [CW-1:0]            r_cnt;
  logic [2:0]               r_bit_idx;
  logic [7:0]               r_shift;
  logic [BCW-1:0]           r_byte_cnt;
  logic [8*FRAME_BYTES-1:0] r_buf;
  logic [8*FRAME_BYTES-1:0] w_buf_next;

  logic w_half_done;
  logic w_bit_done;
  logic w_idle_done;
  logic w_data_smp;
  logic w_stop_good;
  logic w_stop_bad;
  logic w_to;
  logic w_cnt_clr;
  logic w_cnt_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], serial};
  end

  assign w_rx = r_sync[1];

  // One shared counter serves half-bit, bit and idle timing; it clears on every
  // state change and every data sample, so it never has to wrap.
  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_bit_done  = (r_cnt == BIT_LAST);
  assign w_idle_done = (r_byte_cnt != '0) && (r_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (!w_rx) w_state_next = S_START;
      S_START:     if (w_half_done) w_state_next = w_rx ? S_IDLE : S_DATA;
      S_DATA:      if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      S_STOP:      if (w_bit_done) w_state_next = w_rx ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_rx) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_data_smp  = (r_state == S_DATA) && w_bit_done;
    w_stop_good = (r_state == S_STOP) && w_bit_done && w_rx;
    w_stop_bad  = (r_state == S_STOP) && w_bit_done && !w_rx;
    w_to        = (r_state == S_IDLE) && w_idle_done;
    w_cnt_clr   = (w_state_next != r_state) || w_data_smp || w_to;
    w_cnt_run   = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP) ||
                  ((r_state == S_IDLE) && (r_byte_cnt != '0));
    state       = r_state;
  end

  always_comb begin
    w_buf_next = r_buf;
    for (int unsigned k = 0; k < FRAME_BYTES; k++) begin
      if (r_byte_cnt == BCW'(k)) w_buf_next[8*k +: 8] = r_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte_cnt  <= '0;
      r_buf       <= '0;
      frame_data  <= '0;
      byte_data   <= '0;
      frame_valid <= 1'b0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= w_stop_good && (r_byte_cnt == LAST_BYTE);
      byte_valid  <= w_stop_good;
      frame_err   <= w_stop_bad;
      timeout     <= w_to;

      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_run) r_cnt <= r_cnt + 1'b1;

      if ((r_state == S_START) && (w_state_next == S_DATA)) r_bit_idx <= '0;
      else if (w_data_smp)                                  r_bit_idx <= r_bit_idx + 1'b1;

      if (w_data_smp) r_shift[r_bit_idx] <= w_rx;

      if (w_stop_good) begin
        byte_data <= r_shift;
        r_buf     <= w_buf_next;
        if (r_byte_cnt == LAST_BYTE) begin
          frame_data <= w_buf_next;
          r_byte_cnt <= '0;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end else if (w_stop_bad || w_to) begin
        r_byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a fast instance (8 clocks/bit) and a default-rate instance.
module tb_uart_frame_rx;

  localparam int CPB_S = 8;
  localparam int CPB_B = 434;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_s, ser_b;

  logic [39:0] fd_s, fd_b;
  logic [7:0]  bd_s, bd_b;
  logic        fv_s, bv_s, fe_s, to_s;
  logic        fv_b, bv_b, fe_b, to_b;
  logic [2:0]  st_s, st_b;

  int n_checks = 0;
  int n_fail   = 0;

  int n_bv_s = 0, n_fv_s = 0, n_fe_s = 0, n_to_s = 0, n_bad_s = 0;
  int n_bv_b = 0, n_fv_b = 0, n_fe_b = 0;
  logic [39:0] last_frame_s = '0;
  logic [39:0] last_frame_b = '0;

  always #5 clk = ~clk;

  uart_frame_rx #(.CLKS_PER_BIT(CPB_S), .FRAME_BYTES(5), .IDLE_TIMEOUT_BITS(20)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .serial(ser_s),
    .frame_data(fd_s), .frame_valid(fv_s), .byte_data(bd_s), .byte_valid(bv_s),
    .frame_err(fe_s), .timeout(to_s), .state(st_s)
  );

  uart_frame_rx u_dut_b (
    .clk(clk), .rst_n(rst_n), .serial(ser_b),
    .frame_data(fd_b), .frame_valid(fv_b), .byte_data(bd_b), .byte_valid(bv_b),
    .frame_err(fe_b), .timeout(to_b), .state(st_b)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (bv_s) n_bv_s++;
      if (fe_s) n_fe_s++;
      if (to_s) n_to_s++;
      if (fv_s) begin n_fv_s++; last_frame_s = fd_s; end
      if ((bv_s && fe_s) || (fv_s && !bv_s) || (to_s && (bv_s || fe_s))) n_bad_s++;
      if (bv_b) n_bv_b++;
      if (fe_b) n_fe_b++;
      if (fv_b) begin n_fv_b++; last_frame_b = fd_b; end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit big, input logic v, input int cpb);
    if (big) ser_b = v;
    else     ser_s = v;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_byte(input bit big, input int cpb, input logic [7:0] b, input logic stop);
    send_bit(big, 1'b0, cpb);
    for (int i = 0; i < 8; i++) send_bit(big, b[i], cpb);
    send_bit(big, stop, cpb);
  endtask

  task automatic send_frame_s(input logic [39:0] f);
    logic [39:0] v;
    v = f;
    for (int i = 0; i < 5; i++) send_byte(1'b0, CPB_S, v[8*i +: 8], 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    ser_s = 1'b1;
    ser_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(st_s), 64'd0);
    chk("reset_frame_data", 64'(fd_s), 64'd0);
    chk("reset_byte_data", 64'(bd_s), 64'd0);
    chk("reset_pulses", 64'({fv_s, bv_s, fe_s, to_s}), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic five-byte frame
    send_frame_s(40'h55_44_33_22_11);
    @(negedge clk);
    chk("t1_byte_valid_count", 64'(n_bv_s), 64'd5);
    chk("t1_frame_valid_count", 64'(n_fv_s), 64'd1);
    chk("t1_frame_data", 64'(last_frame_s), 64'h55_4433_2211);
    chk("t1_byte_data", 64'(bd_s), 64'h55);
    chk("t1_state_idle", 64'(st_s), 64'd0);

    // Two-cycle low glitch
    repeat (10) @(negedge clk);
    ser_s = 1'b0;
    repeat (2) @(negedge clk);
    ser_s = 1'b1;
    @(negedge clk);
    chk("t2_glitch_start", 64'(st_s), 64'd1);
    repeat (4) @(negedge clk);
    chk("t2_glitch_back_idle", 64'(st_s), 64'd0);
    repeat (20) @(negedge clk);
    chk("t2_no_byte", 64'(n_bv_s), 64'd5);
    chk("t2_no_err", 64'(n_fe_s), 64'd0);

    // Stop-bit error, break, recovery
    send_byte(1'b0, CPB_S, 8'h11, 1'b1);
    send_byte(1'b0, CPB_S, 8'h22, 1'b1);
    send_byte(1'b0, CPB_S, 8'h33, 1'b0);
    repeat (16) @(negedge clk);
    chk("t3_wait_high", 64'(st_s), 64'd4);
    chk("t3_err_count", 64'(n_fe_s), 64'd1);
    chk("t3_frame_held", 64'(fd_s), 64'h55_4433_2211);
    ser_s = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_back_idle", 64'(st_s), 64'd0);
    repeat (8) @(negedge clk);
    send_frame_s(40'hA5_A4_A3_A2_A1);
    @(negedge clk);
    chk("t3_frame_data", 64'(last_frame_s), 64'hA5_A4A3_A2A1);
    chk("t3_byte_count", 64'(n_bv_s), 64'd12);
    chk("t3_frame_count", 64'(n_fv_s), 64'd2);

    // Idle timeout after a partial frame: pulse on the 160th edge after the stop sample
    repeat (10) @(negedge clk);
    send_byte(1'b0, CPB_S, 8'h11, 1'b1);
    send_byte(1'b0, CPB_S, 8'h22, 1'b1);
    repeat (158) @(negedge clk);
    chk("t4_timeout_not_yet", 64'(to_s), 64'd0);
    @(negedge clk);
    chk("t4_timeout_pulse", 64'(to_s), 64'd1);
    @(negedge clk);
    chk("t4_timeout_one_cycle", 64'(to_s), 64'd0);
    send_frame_s(40'h05_04_03_02_01);
    @(negedge clk);
    chk("t4_frame_data", 64'(last_frame_s), 64'h05_0403_0201);
    chk("t4_timeout_count", 64'(n_to_s), 64'd1);

    // Start bit seen on the same edge the timeout completes
    repeat (10) @(negedge clk);
    send_byte(1'b0, CPB_S, 8'h11, 1'b1);
    repeat (156) @(negedge clk);
    fork
      send_frame_s(40'hAA_99_88_77_66);
      begin
        repeat (3) @(negedge clk);
        chk("t5_collide_timeout", 64'(to_s), 64'd1);
        chk("t5_collide_start", 64'(st_s), 64'd1);
      end
    join
    @(negedge clk);
    chk("t5_frame_data", 64'(last_frame_s), 64'hAA_9988_7766);
    chk("t5_timeout_count", 64'(n_to_s), 64'd2);

    // Asynchronous reset in the middle of byte 3
    repeat (10) @(negedge clk);
    send_byte(1'b0, CPB_S, 8'h11, 1'b1);
    send_byte(1'b0, CPB_S, 8'h22, 1'b1);
    send_bit(1'b0, 1'b0, CPB_S);
    send_bit(1'b0, 1'b1, CPB_S);
    send_bit(1'b0, 1'b1, CPB_S);
    send_bit(1'b0, 1'b0, CPB_S);
    chk("t6_mid_data", 64'(st_s), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 64'(st_s), 64'd0);
    chk("t6_rst_frame_data", 64'(fd_s), 64'd0);
    chk("t6_rst_byte_data", 64'(bd_s), 64'd0);
    chk("t6_rst_pulses", 64'({fv_s, bv_s, fe_s, to_s}), 64'd0);
    ser_s = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame_s(40'hC5_C4_C3_C2_C1);
    @(negedge clk);
    chk("t6_frame_data", 64'(last_frame_s), 64'hC5_C4C3_C2C1);
    chk("t6_frame_count", 64'(n_fv_s), 64'd5);
    chk("strobe_exclusivity", 64'(n_bad_s), 64'd0);

    // Default rate, two frames back-to-back with no idle gap
    repeat (10) @(negedge clk);
    send_byte(1'b1, CPB_B, 8'hDE, 1'b1);
    send_byte(1'b1, CPB_B, 8'hAD, 1'b1);
    send_byte(1'b1, CPB_B, 8'hBE, 1'b1);
    send_byte(1'b1, CPB_B, 8'hEF, 1'b1);
    send_byte(1'b1, CPB_B, 8'h01, 1'b1);
    chk("t7_first_frame", 64'(last_frame_b), 64'h01_EFBE_ADDE);
    send_byte(1'b1, CPB_B, 8'h5A, 1'b1);
    send_byte(1'b1, CPB_B, 8'hC3, 1'b1);
    send_byte(1'b1, CPB_B, 8'h3C, 1'b1);
    send_byte(1'b1, CPB_B, 8'hA5, 1'b1);
    send_byte(1'b1, CPB_B, 8'h96, 1'b1);
    repeat (4) @(negedge clk);
    chk("t7_frame_count", 64'(n_fv_b), 64'd2);
    chk("t7_second_frame", 64'(fd_b), 64'h96_A53C_C35A);
    chk("t7_byte_count", 64'(n_bv_b), 64'd10);
    chk("t7_no_err", 64'(n_fe_b), 64'd0);
    chk("t7_byte_data", 64'(bd_b), 64'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
